// File: rtl/rr_mux4_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mux_arb_pkg
// Shared definitions for the round-robin 4:1 mux arbiter:
//   - state_t  : arbiter FSM states (IDLE, GRANT)
//   - NUM_REQ  : number of requesters sharing the output channel
//   - SEL_W    : width of the mux select
//   - rr_pick  : round-robin winner selection starting at a priority pointer
// -----------------------------------------------------------------------------
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Returns the first requester with its bit set, scanning ptr, ptr+1, ...
    // modulo NUM_REQ. The scan runs from the farthest candidate back to ptr,
    // so the closest hit is the last one assigned. With no request it returns
    // ptr; callers only use the result when at least one bit is set.
    function automatic logic [SEL_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [SEL_W-1:0]   ptr
    );
        logic [SEL_W-1:0] idx;
        rr_pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/rr_mux4_arbiter_if.sv
// -----------------------------------------------------------------------------
// rr_mux4_arbiter_if
// Bundles the requester side and the downstream side of the shared channel.
//   req       : requester i has a beat valid on in_data/in_last
//   in_data   : requester i occupies bits [i*WIDTH +: WIDTH]
//   in_last   : final beat of requester i's packet
//   in_ready  : one-hot accept back to the granted requester
//   out_valid : muxed beat valid
//   out_data  : muxed beat data
//   out_last  : muxed last flag
//   out_ready : downstream accepts the beat
//   sel       : current mux select (0..3)
//   busy      : arbiter is in GRANT
// Modports: slave = the arbiter, master = the environment around it.
// -----------------------------------------------------------------------------
interface rr_mux4_arbiter_if
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = 8
) ();

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] in_data;
    logic [NUM_REQ-1:0]       in_last;
    logic [NUM_REQ-1:0]       in_ready;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;
    logic                     out_last;
    logic                     out_ready;
    logic [SEL_W-1:0]         sel;
    logic                     busy;

    modport slave (
        input  req, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, sel, busy
    );

    modport master (
        output req, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, sel, busy
    );

endinterface

// File: rtl/rr_mux4_arbiter_mux4_data.sv
// -----------------------------------------------------------------------------
// mux4_data
// Combinational W-wide 4:1 multiplexer.
//   i_data : four W-bit lanes, lane n at [n*W +: W]
//   i_sel  : lane select
//   o_data : selected lane
// -----------------------------------------------------------------------------
module mux4_data
    import mux_arb_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [NUM_REQ*W-1:0] i_data,
    input  logic [SEL_W-1:0]     i_sel,
    output logic [W-1:0]         o_data
);

    assign o_data = i_data[i_sel*W +: W];

endmodule

// File: rtl/rr_mux4_arbiter.sv
// -----------------------------------------------------------------------------
// rr_mux4_arbiter
// Round-robin arbiter sharing one 4:1 multiplexed output channel between four
// packet requesters. A winner is picked in IDLE (one cycle), then its beats
// pass through combinationally until a transfer carries last, or until
// MAX_BEATS beats have been accepted in this grant (watchdog release).
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : rr_mux4_arbiter_if.slave (requesters, downstream, sel, busy)
// -----------------------------------------------------------------------------
module rr_mux4_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    rr_mux4_arbiter_if.slave      bus
);

    localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    state_t             r_state, w_next_state;
    logic [SEL_W-1:0]   r_sel,   w_next_sel;
    logic [SEL_W-1:0]   r_ptr,   w_next_ptr;
    logic [CNT_W-1:0]   r_cnt,   w_next_cnt;

    logic               w_busy;
    logic               w_out_valid;
    logic               w_out_last;
    logic               w_transfer;
    logic               w_release;

    // ---------------------------------------------------------------- datapath
    mux4_data #(.W(WIDTH)) u_mux_data (
        .i_data (bus.in_data),
        .i_sel  (r_sel),
        .o_data (bus.out_data)
    );

    mux4_data #(.W(1)) u_mux_last (
        .i_data (bus.in_last),
        .i_sel  (r_sel),
        .o_data (w_out_last)
    );

    assign w_busy      = (r_state == GRANT);
    assign w_out_valid = w_busy & bus.req[r_sel];
    assign w_transfer  = w_out_valid & bus.out_ready;
    // Release on the packet's last beat, or when this beat fills the budget.
    assign w_release   = w_transfer &
                         (w_out_last | (r_cnt == CNT_W'(MAX_BEATS - 1)));

    assign bus.out_valid = w_out_valid;
    assign bus.out_last  = w_out_last;
    assign bus.sel       = r_sel;
    assign bus.busy      = w_busy;
    // in_ready follows out_ready for the granted lane even if it is not
    // requesting, so the requester sees a plain pass-through of the channel.
    assign bus.in_ready  = (w_busy & bus.out_ready) ? (NUM_REQ'(1) << r_sel)
                                                    : '0;

    // ------------------------------------------------------------ state regs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            r_state <= w_next_state;
            r_sel   <= w_next_sel;
            r_ptr   <= w_next_ptr;
            r_cnt   <= w_next_cnt;
        end
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        // NOTE: hold-by-default on every output keeps this block latch-free.
        w_next_state = r_state;
        w_next_sel   = r_sel;
        w_next_ptr   = r_ptr;
        w_next_cnt   = r_cnt;

        unique case (r_state)
            IDLE: begin
                if (|bus.req) begin
                    w_next_state = GRANT;
                    w_next_sel   = rr_pick(bus.req, r_ptr);
                    w_next_cnt   = '0;
                end
            end
            GRANT: begin
                // Only accepted beats count; idle cycles inside a grant do not.
                if (w_transfer) begin
                    w_next_cnt = r_cnt + 1'b1;
                end
                if (w_release) begin
                    w_next_state = IDLE;
                    w_next_ptr   = r_sel + 1'b1;
                    w_next_cnt   = '0;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule

// File: doc/rr_mux4_arbiter.md
Name: rr_mux4_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 4-to-1 multiplexed output channel between four requesters.
- Each requester presents a packet of data beats. The arbiter picks a winner, drives the 2-bit select {s1,s0} of the mux datapath, and holds that selection until the winner's packet completes.
- It sits in front of any single-consumer resource fed by the 4:1 mux.

Parameters:
- WIDTH, 8, data width per requester and per output beat.
- MAX_BEATS, 16, beat limit per grant; forced release when reached (watchdog against a stuck requester).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  req[i] high: requester i has a beat valid on in_data/in_last.
- in_data  input  4*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
- in_last  input  4  in_last[i] marks the final beat of requester i's packet.
- in_ready  output  4  one-hot; in_ready[i] = out_ready while i is granted, else 0.
- out_valid  output  1  muxed beat valid.
- out_data  output  WIDTH  muxed data.
- out_last  output  1  muxed last flag.
- out_ready  input  1  downstream accepts the beat.
- sel  output  2  current mux select {s1,s0}; 0=i0, 1=i1, 2=i2, 3=i3.
- busy  output  1  high while in GRANT.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, sel=0, priority pointer ptr=0, beat counter cnt=0.
  - in_ready=0, out_valid=0, busy=0.
- Datapath (combinational from sel):
  - out_data = in_data[sel], out_last = in_last[sel].
  - out_valid = busy & req[sel].
  - in_ready[sel] = busy & out_ready.
  - No registered data; zero-latency pass-through once granted.
- Handshake:
  - A beat transfers when out_valid & out_ready.
  - Requesters must hold in_data/in_last stable while req is high and unaccepted.
- FSM, 2 states:
  - IDLE: if any req bit is high, choose the first requester at or after ptr, scanning ptr, ptr+1, ... mod 4. Register sel=winner, cnt=0, go to GRANT on the next edge. Arbitration costs exactly one cycle; no beat transfers in IDLE.
  - GRANT: each transfer increments cnt. Release the grant on a transfer with out_last=1, or a transfer with cnt==MAX_BEATS-1.
  - On release: go to IDLE, set ptr = sel+1 mod 4 (wrap from 3 to 0). sel holds its value in IDLE.
  - Back-to-back packets therefore have a one-cycle IDLE gap.
- Boundary conditions:
  - req[sel] dropping mid-packet: grant held, out_valid=0, no timeout on idle cycles (only beats count).
  - Other req bits changing during GRANT: ignored.
  - Single requester active continuously: it is re-granted after every IDLE cycle.
  - All four requesting: grant order ptr, ptr+1, ptr+2, ptr+3; no requester waits more than 3 packets.
  - One-beat packet (in_last on the first beat): GRANT lasts one transfer cycle.
  - Forced release at MAX_BEATS without in_last: remaining beats are arbitrated later as a new grant.
  - rst asserted mid-packet: immediate return to reset values; partial packet is abandoned.
- Width rules:
  - cnt is $clog2(MAX_BEATS) bits, compared to MAX_BEATS-1.
  - ptr is 2 bits with natural wrap.

Decomposition:
- Shared package mux_arb_pkg:
  - state enum {IDLE, GRANT}.
  - NUM_REQ=4 and SEL_W=2 constants.
  - function rr_pick(req, ptr) returning the 2-bit winner.
- One natural sub-module, mux4_data: the combinational WIDTH-wide 4:1 mux driven by sel, instantiated once for data and once for last.
- FSM, pointer and counter remain in the top.

Test Plan:
- Reset mid-transfer: grant 2, assert rst during beat 2 -> same cycle busy=0, out_valid=0, in_ready=0000, sel=0; after release, req=0100 is granted again from ptr=0 scan (winner 2).
- Single request: req=0010, 3-beat packet, out_ready=1 -> IDLE 1 cycle, then sel=1, busy=1, data beats appear with out_valid=1 on 3 consecutive cycles, in_ready=0010; release after last; ptr=2.
- Fairness: req=1111 held, 1-beat packets each -> grant order 0,1,2,3,0 with one IDLE cycle between grants; sel sequence 0,1,2,3,0.
- Backpressure: grant 3, out_ready=0 for 4 cycles -> out_valid=1, out_data stable, in_ready=0000, cnt unchanged; out_ready=1 resumes transfer.
- Watchdog: MAX_BEATS=16, requester 0 streams with no in_last -> release after the 16th accepted beat, next grant goes to a pending requester 1, not 0.
- Requester drops req mid-packet for 5 cycles while req=1000 pending -> grant held on 0, out_valid=0; after 0 sends last, grant 3.
